// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
// Shared types and defaults for the run/step controller.
//   run_state_t         : controller state encoding
//   DEBOUNCE_CYCLES_DEF : stable samples needed to accept a button level (10 ms at 125 MHz)
//   CNT_W_DEF           : default width of the issued-cycle counter
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } run_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_250_000;
    localparam int CNT_W_DEF           = 32;

endpackage

// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if
// Connection between the run controller and the core it gates.
//   halt_req  : core -> ctrl, trap asks the controller to stop issuing enables
//   core_en   : ctrl -> core, single-cycle clock enable
//   halted    : ctrl -> core/display, controller is in HALT
//   cycle_cnt : ctrl -> display, enables issued since reset
interface core_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             halt_req;
    logic             core_en;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        input  halt_req,
        output core_en,
        output halted,
        output cycle_cnt
    );

    modport slave (
        output halt_req,
        input  core_en,
        input  halted,
        input  cycle_cnt
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronises a raw bouncing push-button and emits one pulse per accepted press.
//   clk_in : system clock
//   rst    : asynchronous active-low reset
//   btn    : raw active-high button, asynchronous
//   press  : one-cycle pulse on an accepted 0->1 level change
module btn_debounce
    import core_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Any sample agreeing with the accepted level restarts the count, so a
    // bounce shorter than the window never gets accepted.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl
// Turns rising edges of the divided slow clock into single-cycle core enables,
// in free-run mode or one per debounced step press; honours core halt requests.
//   clk_in   : 125 MHz system clock
//   rst      : asynchronous active-low reset
//   slow_clk : divided clock, asynchronous
//   run_sw   : free-run switch, asynchronous
//   step_btn : raw step button, asynchronous
//   core     : core-side interface (halt_req in; core_en, halted, cycle_cnt out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_HALT | no enables; wait for run switch (unlocked) or a step press
// ST_RUN  | one enable per slow_clk rise
// ST_STEP | one enable on the next slow_clk rise, then back to ST_HALT
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             run_sw,
    input  logic             step_btn,
    core_run_ctrl_if.master  core
);
    logic             slow_s1, slow_s2, slow_s3;
    logic             run_s1, run_sw_s;
    logic             tick;
    logic             step_press;
    run_state_t       state, state_n;
    logic             halt_lock;
    logic             lock_set;
    logic             core_en_n;
    logic             core_en_q;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            slow_s1  <= 1'b0;
            slow_s2  <= 1'b0;
            slow_s3  <= 1'b0;
            run_s1   <= 1'b0;
            run_sw_s <= 1'b0;
        end else begin
            slow_s1  <= slow_clk;
            slow_s2  <= slow_s1;
            slow_s3  <= slow_s2;
            run_s1   <= run_sw;
            run_sw_s <= run_s1;
        end
    end

    assign tick = slow_s2 & ~slow_s3;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk_in (clk_in),
        .rst    (rst),
        .btn    (step_btn),
        .press  (step_press)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= ST_HALT;
            core_en_q <= 1'b0;
            halted_q  <= 1'b1;
        end else begin
            state     <= state_n;
            core_en_q <= core_en_n;
            halted_q  <= (state_n == ST_HALT);
        end
    end

    // halt_req outranks the switch, which outranks tick.
    always_comb begin
        state_n   = state;
        core_en_n = 1'b0;
        lock_set  = 1'b0;
        case (state)
            ST_HALT: begin
                if (run_sw_s && !halt_lock) begin
                    state_n = ST_RUN;
                end else if (step_press) begin
                    state_n = ST_STEP;
                end
            end
            ST_RUN: begin
                if (core.halt_req) begin
                    state_n  = ST_HALT;
                    lock_set = 1'b1;
                end else if (!run_sw_s) begin
                    state_n = ST_HALT;
                end else if (tick) begin
                    core_en_n = 1'b1;
                end
            end
            ST_STEP: begin
                if (core.halt_req) begin
                    state_n  = ST_HALT;
                    lock_set = 1'b1;
                end else if (tick) begin
                    core_en_n = 1'b1;
                    state_n   = ST_HALT;
                end
            end
            default: state_n = ST_HALT;
        endcase
    end

    // The lock survives while the switch stays on, so a trapped core only
    // free-runs again after the switch is cycled off and on.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            halt_lock <= 1'b0;
        end else if (!run_sw_s) begin
            halt_lock <= 1'b0;
        end else if (lock_set) begin
            halt_lock <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (core_en_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign core.core_en   = core_en_q;
    assign core.halted    = halted_q;
    assign core.cycle_cnt = cnt_q;
endmodule
